// File: rtl/multiboot_icap_seq.sv
// Spartan-6 multiboot sequencer: streams the ICAP warm-boot command list with run-time
// target address, 1x/4x SPI read mode, a filtered REBOOT pin and busy/done status.
module multiboot_icap_seq #(
    parameter logic [23:0] DEFAULT_ADDR = 24'h098000,
    parameter logic        DEFAULT_QUAD = 1'b0,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FILTER_LEN   = 3,
    parameter int unsigned NOOP_COUNT   = 4
) (
    input  logic        CLK,
    input  logic        MBT_RESET,
    input  logic        REBOOT,
    input  logic        boot_req,
    input  logic [23:0] addr_in,
    input  logic        quad_in,
    input  logic        cfg_we,
    output logic        busy,
    output logic        done,
    output logic        icap_ce,
    output logic        icap_wr,
    output logic [15:0] icap_i
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StSync = 3'd1;
    localparam logic [2:0] StHdr  = 3'd2;
    localparam logic [2:0] StMode = 3'd3;
    localparam logic [2:0] StCmd  = 3'd4;
    localparam logic [2:0] StNoop = 3'd5;

    localparam logic [3:0] NoopCnt = 4'(NOOP_COUNT);
    localparam logic [FILTER_LEN:0] FirePattern = {1'b1, {FILTER_LEN{1'b0}}};

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILTER_LEN:0]    hist_q;
    logic [2:0]             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [23:0]            addr_q, addr_d, snap_addr_q, snap_addr_d;
    logic                   quad_q, quad_d, snap_quad_q, snap_quad_d;
    logic                   fin_q, fin_d;
    logic                   busy_q, busy_d, done_q;
    logic                   ce_q, wr_q, ce_d;
    logic [15:0]            data_q, data_d;
    logic                   pin_fire, trig;
    logic [15:0]            word;
    logic [7:0]             op;

    // A falling edge counts only once the pin has stayed low for FILTER_LEN samples.
    assign pin_fire = (hist_q == FirePattern);
    assign trig     = boot_req | pin_fire;

    assign addr_d = cfg_we ? addr_in : addr_q;
    assign quad_d = cfg_we ? quad_in : quad_q;
    assign op     = snap_quad_q ? 8'h6B : 8'h03;

    always_comb begin
        word = 16'hFFFF;
        case (state_q)
            StSync: word = cnt_q[0] ? 16'h5566 : 16'hAA99;
            StHdr: begin
                case (cnt_q[2:0])
                    3'd0:    word = 16'h30A1;
                    3'd1:    word = 16'h0000;
                    3'd2:    word = 16'h3261;
                    3'd3:    word = snap_addr_q[15:0];
                    3'd4:    word = 16'h3281;
                    default: word = {op, snap_addr_q[23:16]};
                endcase
            end
            StMode:  word = cnt_q[0] ? 16'h2100 : 16'h3301;
            StCmd:   word = cnt_q[0] ? 16'h000E : 16'h30A1;
            StNoop:  word = 16'h2000;
            default: word = 16'hFFFF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_addr_d = snap_addr_q;
        snap_quad_d = snap_quad_q;
        fin_d       = 1'b0;
        case (state_q)
            StIdle: begin
                if (trig) begin
                    state_d     = StSync;
                    cnt_d       = 4'd0;
                    snap_addr_d = addr_d;
                    snap_quad_d = quad_d;
                end
            end
            StSync: begin
                if (cnt_q == 4'd1) begin
                    state_d = StHdr;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHdr: begin
                if (cnt_q == 4'd5) begin
                    state_d = snap_quad_q ? StMode : StCmd;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StMode: begin
                if (cnt_q == 4'd1) begin
                    state_d = StCmd;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCmd: begin
                if (cnt_q == 4'd1) begin
                    state_d = StNoop;
                    cnt_d   = NoopCnt;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StNoop: begin
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                    fin_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs reflect the word selected by the current state, one edge later.
    assign busy_d = (state_q != StIdle);
    assign ce_d   = ~busy_d;
    assign data_d = busy_d ? {bitrev8(word[15:8]), bitrev8(word[7:0])} : 16'hFFFF;

    always_ff @(posedge CLK) begin
        if (MBT_RESET) begin
            sync_q      <= '0;
            hist_q      <= '0;
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= DEFAULT_ADDR;
            quad_q      <= DEFAULT_QUAD;
            snap_addr_q <= DEFAULT_ADDR;
            snap_quad_q <= DEFAULT_QUAD;
            fin_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ce_q        <= 1'b1;
            wr_q        <= 1'b1;
            data_q      <= 16'hFFFF;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], REBOOT};
            hist_q      <= {hist_q[FILTER_LEN-1:0], sync_q[SYNC_STAGES-1]};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            quad_q      <= quad_d;
            snap_addr_q <= snap_addr_d;
            snap_quad_q <= snap_quad_d;
            fin_q       <= fin_d;
            busy_q      <= busy_d;
            done_q      <= fin_q;
            ce_q        <= ce_d;
            wr_q        <= ce_d;
            data_q      <= data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign icap_ce = ce_q;
    assign icap_wr = wr_q;
    assign icap_i  = data_q;

endmodule

// File: tb/tb_multiboot_icap_seq.sv
// Directed bench for multiboot_icap_seq: default and 4x sequences, pin filter, dropped
// requests, mid-sequence reset and a single-NOOP build.
module tb_multiboot_icap_seq;

    logic        CLK = 1'b0;
    logic        MBT_RESET, REBOOT, boot_req, quad_in, cfg_we;
    logic [23:0] addr_in;
    logic        busy, done, icap_ce, icap_wr;
    logic [15:0] icap_i;
    logic        busy1, done1, icap_ce1, icap_wr1;
    logic [15:0] icap_i1;

    always #5 CLK = ~CLK;

    multiboot_icap_seq u_dut (
        .CLK(CLK), .MBT_RESET(MBT_RESET), .REBOOT(REBOOT), .boot_req(boot_req),
        .addr_in(addr_in), .quad_in(quad_in), .cfg_we(cfg_we), .busy(busy), .done(done),
        .icap_ce(icap_ce), .icap_wr(icap_wr), .icap_i(icap_i)
    );

    multiboot_icap_seq #(.NOOP_COUNT(1)) u_dut_n1 (
        .CLK(CLK), .MBT_RESET(MBT_RESET), .REBOOT(REBOOT), .boot_req(boot_req),
        .addr_in(addr_in), .quad_in(quad_in), .cfg_we(cfg_we), .busy(busy1), .done(done1),
        .icap_ce(icap_ce1), .icap_wr(icap_wr1), .icap_i(icap_i1)
    );

    // Status word: {ce, wr, busy, done, data}
    logic [19:0] st, st1;
    assign st  = {icap_ce, icap_wr, busy, done, icap_i};
    assign st1 = {icap_ce1, icap_wr1, busy1, done1, icap_i1};

    localparam logic [19:0] Idle     = {4'b1100, 16'hFFFF};
    localparam logic [19:0] IdleDone = {4'b1101, 16'hFFFF};

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_w [0:15];
    int exp_len;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] brev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7-i];
            r[8+i]   = w[15-i];
        end
        return r;
    endfunction

    function automatic logic [19:0] active(input logic [15:0] w);
        return {4'b0010, brev16(w)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Trigger inputs must already be set; the first tick here is the trigger edge T.
    task automatic run_seq(input string tag, input bit inject, input bit chk_short);
        tick();
        boot_req = 1'b0;
        cfg_we   = 1'b0;
        for (int k = 0; k < exp_len; k++) begin
            tick();
            boot_req = 1'b0;
            check_eq($sformatf("%s word%0d", tag, k), 32'(st), 32'(active(exp_w[k])));
            if (chk_short) begin
                if (k < 11)
                    check_eq($sformatf("%s n1 word%0d", tag, k), 32'(st1), 32'(active(exp_w[k])));
                else if (k == 11)
                    check_eq($sformatf("%s n1 done", tag), 32'(st1), 32'(IdleDone));
            end
            if (inject && (k == 2 || k == 8)) boot_req = 1'b1;
        end
        tick();
        boot_req = 1'b0;
        check_eq($sformatf("%s done", tag), 32'(st), 32'(IdleDone));
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("%s idle%0d", tag, i), 32'(st), 32'(Idle));
        end
    endtask

    task automatic load_default();
        exp_w = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h8000, 16'h3281,
                  16'h0309, 16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000, 16'h2000,
                  16'h0000, 16'h0000};
        exp_len = 14;
    endtask

    task automatic load_quad();
        exp_w = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h0000, 16'h3281,
                  16'h6B0B, 16'h3301, 16'h2100, 16'h30A1, 16'h000E, 16'h2000, 16'h2000,
                  16'h2000, 16'h2000};
        exp_len = 16;
    endtask

    int seen;

    initial begin
        REBOOT = 1'b1; boot_req = 1'b0; addr_in = '0; quad_in = 1'b0; cfg_we = 1'b0;
        MBT_RESET = 1'b1;
        tick(); tick();
        MBT_RESET = 1'b0;
        check_eq("reset", 32'(st), 32'(Idle));
        check_eq("reset n1", 32'(st1), 32'(Idle));
        tick();
        check_eq("reset hold", 32'(st), 32'(Idle));

        // Default 1x sequence, plus the single-NOOP build in lockstep
        load_default();
        check_eq("t1 map 30A1", 32'(brev16(exp_w[2])), 32'h0C85);
        boot_req = 1'b1;
        run_seq("t1", 1'b0, 1'b1);

        // cfg_we together with the trigger: new 4x target used immediately
        load_quad();
        addr_in = 24'h0B0000; quad_in = 1'b1; cfg_we = 1'b1; boot_req = 1'b1;
        run_seq("t2", 1'b0, 1'b0);

        // Requests while busy are dropped
        boot_req = 1'b1;
        run_seq("t4", 1'b1, 1'b0);

        // Filtered pin falling edge after a long high period
        for (int i = 0; i < 10; i++) tick();
        REBOOT = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("t3 pre%0d busy", i), 32'(busy), 32'd0);
        end
        tick();
        check_eq("t3 start", 32'(st), 32'(active(16'hAA99)));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) seen++;
        end
        check_eq("t3 done count", 32'(seen), 32'd1);
        REBOOT = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) seen++;
        end
        REBOOT = 1'b0;
        tick(); tick();
        REBOOT = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) seen++;
        end
        check_eq("t3 glitch busy cycles", 32'(seen), 32'd0);

        // Reset mid-sequence, then the defaults are back
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq($sformatf("t5 word%0d", k), 32'(st), 32'(active(exp_w[k])));
        end
        MBT_RESET = 1'b1;
        tick();
        MBT_RESET = 1'b0;
        check_eq("t5 after reset", 32'(st), 32'(Idle));
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy || done) seen++;
        end
        check_eq("t5 quiet", 32'(seen), 32'd0);
        load_default();
        boot_req = 1'b1;
        run_seq("t5b", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
